// File: rtl/mmio_uart_bridge_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mmio_uart_bridge_if : byte-stream rx/tx handshakes plus FPro MMIO bus   rev 1.0
// ---------------------------------------------------------------------------
interface mmio_uart_bridge_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        mmio_cs;
    logic        mmio_wr;
    logic        mmio_rd;
    logic [20:0] mmio_addr;
    logic [31:0] mmio_wr_data;
    logic [31:0] mmio_rd_data;

    // Bridge side: consumes rx bytes, produces tx bytes, masters the MMIO bus.
    modport master (
        input  rx_data, rx_valid,
        output rx_ready,
        output tx_data, tx_valid,
        input  tx_ready,
        output mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
        input  mmio_rd_data
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready,
        input  tx_data, tx_valid,
        output tx_ready,
        input  mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
        output mmio_rd_data
    );
endinterface
`default_nettype wire

// File: rtl/mmio_uart_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mmio_uart_bridge : host byte-command parser driving one FPro MMIO cycle   rev 1.0
// ---------------------------------------------------------------------------
module mmio_uart_bridge #(
    parameter int TIMEOUT = 100_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    mmio_uart_bridge_if.master         bus,
    output logic                       busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_BUS  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    localparam int           TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit           TO_EN  = (TIMEOUT > 0);
    localparam logic [TW-1:0] TMAX  = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [7:0]   OP_WR  = 8'h57;
    localparam logic [7:0]   OP_RD  = 8'h52;
    localparam logic [7:0]   RSP_OK = 8'h4B;
    localparam logic [7:0]   RSP_ER = 8'h3F;

    state_t          state_q;
    logic [1:0]      cnt_q;
    logic [1:0]      last_q;
    logic [TW-1:0]   timer_q;
    logic            is_wr_q;
    logic [31:0]     resp_q;
    logic            tx_valid_q;
    logic            cs_q;
    logic            wr_q;
    logic            rd_q;
    logic [20:0]     addr_q;
    logic [31:0]     wdata_q;

    logic            w_rx_ready;
    logic            w_rx_acc;
    logic            w_tx_xfer;

    assign w_rx_ready = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA);
    assign w_rx_acc   = bus.rx_valid & w_rx_ready;
    assign w_tx_xfer  = tx_valid_q & bus.tx_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            last_q     <= 2'd0;
            timer_q    <= '0;
            is_wr_q    <= 1'b0;
            resp_q     <= 32'h0;
            tx_valid_q <= 1'b0;
            cs_q       <= 1'b0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            addr_q     <= 21'h0;
            wdata_q    <= 32'h0;
        end else begin
            // Strobes are high only for the single cycle spent in S_BUS.
            cs_q <= 1'b0;
            wr_q <= 1'b0;
            rd_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q   <= 2'd0;
                    timer_q <= '0;
                    if (w_rx_acc) begin
                        if (bus.rx_data == OP_WR || bus.rx_data == OP_RD) begin
                            is_wr_q <= (bus.rx_data == OP_WR);
                            state_q <= S_ADDR;
                        end else begin
                            resp_q     <= {RSP_ER, 24'h0};
                            last_q     <= 2'd0;
                            tx_valid_q <= 1'b1;
                            state_q    <= S_RESP;
                        end
                    end
                end
                S_ADDR: begin
                    if (w_rx_acc) begin
                        // Shifting 24 bits through a 21-bit register drops the top 3 address bits.
                        addr_q  <= {addr_q[12:0], bus.rx_data};
                        timer_q <= '0;
                        if (cnt_q == 2'd2) begin
                            cnt_q <= 2'd0;
                            if (is_wr_q) begin
                                state_q <= S_DATA;
                            end else begin
                                state_q <= S_BUS;
                                cs_q    <= 1'b1;
                                rd_q    <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end else if (TO_EN && timer_q == TMAX) begin
                        state_q <= S_IDLE;
                        cnt_q   <= 2'd0;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_rx_acc) begin
                        wdata_q <= {wdata_q[23:0], bus.rx_data};
                        timer_q <= '0;
                        if (cnt_q == 2'd3) begin
                            cnt_q   <= 2'd0;
                            state_q <= S_BUS;
                            cs_q    <= 1'b1;
                            wr_q    <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end else if (TO_EN && timer_q == TMAX) begin
                        state_q <= S_IDLE;
                        cnt_q   <= 2'd0;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_BUS: begin
                    resp_q     <= is_wr_q ? {RSP_OK, 24'h0} : bus.mmio_rd_data;
                    last_q     <= is_wr_q ? 2'd0 : 2'd3;
                    tx_valid_q <= 1'b1;
                    cnt_q      <= 2'd0;
                    state_q    <= S_RESP;
                end
                S_RESP: begin
                    if (w_tx_xfer) begin
                        if (cnt_q == last_q) begin
                            tx_valid_q <= 1'b0;
                            cnt_q      <= 2'd0;
                            state_q    <= S_IDLE;
                        end else begin
                            resp_q <= {resp_q[23:0], 8'h00};
                            cnt_q  <= cnt_q + 2'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rx_ready     = w_rx_ready;
    assign bus.tx_data      = resp_q[31:24];
    assign bus.tx_valid     = tx_valid_q;
    assign bus.mmio_cs      = cs_q;
    assign bus.mmio_wr      = wr_q;
    assign bus.mmio_rd      = rd_q;
    assign bus.mmio_addr    = addr_q;
    assign bus.mmio_wr_data = wdata_q;
    assign busy             = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mmio_uart_bridge : randomized self-checking bench for mmio_uart_bridge   rev 1.0
// ---------------------------------------------------------------------------
module tb_mmio_uart_bridge;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    always #5 clk = ~clk;

    mmio_uart_bridge_if bif ();
    mmio_uart_bridge #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.master),
        .busy  (busy)
    );

    // Read data is only meaningful during the strobe; garbage otherwise exposes a late capture.
    logic [31:0] rd_val;
    assign bif.mmio_rd_data = bif.mmio_cs ? rd_val : 32'hDEAD_BEEF;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [20:0] addr;
        logic [31:0] wd;
    } op_t;
    op_t        mon_q[$];
    op_t        mon_e;
    logic [7:0] cmd [8];
    logic [7:0] got [4];
    int         first_cyc;
    int         last_cyc;

    always @(negedge clk) begin
        if (bif.mmio_cs) begin
            mon_e.wr   = bif.mmio_wr;
            mon_e.rd   = bif.mmio_rd;
            mon_e.addr = bif.mmio_addr;
            mon_e.wd   = bif.mmio_wr_data;
            mon_q.push_back(mon_e);
            total++;
            if (bif.mmio_wr === bif.mmio_rd) begin
                bad++;
                $display("FAIL strobe_excl: wr=%b rd=%b, need exactly one", bif.mmio_wr, bif.mmio_rd);
            end
        end else if (bif.mmio_wr || bif.mmio_rd) begin
            total++;
            bad++;
            $display("FAIL strobe_no_cs: wr=%b rd=%b, need 0 while cs=0", bif.mmio_wr, bif.mmio_rd);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bif.rx_data  = b;
        bif.rx_valid = 1'b1;
        @(negedge clk);
        while (!bif.rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bif.rx_ready !== 1'b1) begin
            bad++;
            $display("FAIL rx_accept: rx_ready=%b after 50 cycles, need 1", bif.rx_ready);
        end
        @(posedge clk);
        #1;
        bif.rx_valid = 1'b0;
    endtask

    // mode 0: tx_ready high, 1: toggle 1,0,1,0..., 2: random
    task automatic recv(input int n, input int mode);
        int         cnt = 0;
        int         cyc = 0;
        logic       held_v = 1'b0;
        logic [7:0] held = 8'h00;
        first_cyc = -1;
        last_cyc  = -1;
        while (cnt < n && cyc < 200) begin
            bif.tx_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom);
            @(negedge clk);
            if (held_v && bif.tx_valid) begin
                total++;
                if (bif.tx_data !== held) begin
                    bad++;
                    $display("FAIL tx_hold: tx_data=%h changed, need %h", bif.tx_data, held);
                end
            end
            held_v = 1'b0;
            if (bif.tx_valid && bif.tx_ready) begin
                if (cnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                got[cnt] = bif.tx_data;
                cnt++;
            end else if (bif.tx_valid) begin
                held_v = 1'b1;
                held   = bif.tx_data;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bif.tx_ready = 1'b0;
        total++;
        if (cnt != n) begin
            bad++;
            $display("FAIL rx_resp_count: got %0d bytes, need %0d", cnt, n);
        end
    endtask

    // Reference model derives bus op and response directly from the command bytes.
    task automatic do_cmd(input int mode, input int gap_at, input int gap_len);
        logic [7:0]  exp_b [4];
        int          exp_n;
        int          n_send;
        logic        has_op;
        logic        op_wr;
        logic [23:0] a24;
        logic [31:0] wd;
        a24 = {cmd[1], cmd[2], cmd[3]};
        wd  = {cmd[4], cmd[5], cmd[6], cmd[7]};
        if (cmd[0] == 8'h57) begin
            has_op = 1'b1; op_wr = 1'b1; n_send = 8; exp_n = 1; exp_b[0] = 8'h4B;
        end else if (cmd[0] == 8'h52) begin
            has_op = 1'b1; op_wr = 1'b0; n_send = 4; exp_n = 4;
            for (int i = 0; i < 4; i++) exp_b[i] = 8'((rd_val >> (24 - 8 * i)) & 32'hFF);
        end else begin
            has_op = 1'b0; op_wr = 1'b0; n_send = 1; exp_n = 1; exp_b[0] = 8'h3F;
        end
        mon_q.delete();
        for (int i = 0; i < n_send; i++) begin
            send_byte(cmd[i]);
            if (i == gap_at) begin
                repeat (gap_len) @(posedge clk);
                #1;
            end
        end
        total++;
        if (bif.mmio_cs !== has_op) begin
            bad++;
            $display("FAIL bus_latency: cs=%b after last byte, need %b", bif.mmio_cs, has_op);
        end
        recv(exp_n, mode);
        for (int i = 0; i < exp_n; i++) begin
            total++;
            if (got[i] !== exp_b[i]) begin
                bad++;
                $display("FAIL resp_byte%0d: got %h, need %h", i, got[i], exp_b[i]);
            end
        end
        if (mode == 0) begin
            total++;
            if (first_cyc != (has_op ? 1 : 0) || last_cyc != first_cyc + exp_n - 1) begin
                bad++;
                $display("FAIL resp_timing: first=%0d last=%0d, need first=%0d last=%0d",
                         first_cyc, last_cyc, has_op ? 1 : 0, (has_op ? 1 : 0) + exp_n - 1);
            end
        end
        total++;
        if (mon_q.size() != (has_op ? 1 : 0)) begin
            bad++;
            $display("FAIL bus_count: %0d cs cycles, need %0d", mon_q.size(), has_op ? 1 : 0);
        end else if (has_op) begin
            total++;
            if (mon_q[0].wr !== op_wr || mon_q[0].rd !== !op_wr || mon_q[0].addr !== a24[20:0] ||
                (op_wr && mon_q[0].wd !== wd)) begin
                bad++;
                $display("FAIL bus_op: wr=%b rd=%b addr=%h wd=%h, need wr=%b addr=%h wd=%h",
                         mon_q[0].wr, mon_q[0].rd, mon_q[0].addr, mon_q[0].wd, op_wr, a24[20:0], wd);
            end
        end
        total++;
        if (bif.tx_valid !== 1'b0 || bif.rx_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL end_state: tx_valid=%b rx_ready=%b busy=%b, need 0 1 0",
                     bif.tx_valid, bif.rx_ready, busy);
        end
    endtask

    task automatic set_read(input logic [23:0] a);
        cmd[0] = 8'h52; cmd[1] = a[23:16]; cmd[2] = a[15:8]; cmd[3] = a[7:0];
    endtask

    task automatic set_write(input logic [23:0] a, input logic [31:0] d);
        cmd[0] = 8'h57; cmd[1] = a[23:16]; cmd[2] = a[15:8]; cmd[3] = a[7:0];
        cmd[4] = d[31:24]; cmd[5] = d[23:16]; cmd[6] = d[15:8]; cmd[7] = d[7:0];
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bif.rx_valid = 1'b0; bif.rx_data = 8'h00; bif.tx_ready = 1'b0; rd_val = 32'h0;
        #12;
        total++;
        if (bif.tx_valid !== 1'b0 || bif.tx_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_tx: tx_valid=%b tx_data=%h, need 0 00", bif.tx_valid, bif.tx_data);
        end
        total++;
        if (bif.mmio_cs !== 1'b0 || bif.mmio_wr !== 1'b0 || bif.mmio_rd !== 1'b0 ||
            bif.mmio_addr !== 21'h0 || bif.mmio_wr_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_mmio: cs=%b wr=%b rd=%b addr=%h wd=%h, need all 0",
                     bif.mmio_cs, bif.mmio_wr, bif.mmio_rd, bif.mmio_addr, bif.mmio_wr_data);
        end
        total++;
        if (busy !== 1'b0 || bif.rx_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: busy=%b rx_ready=%b, need 0 1", busy, bif.rx_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write;
        set_write(24'h000040, 32'h0000_00A5);
        do_cmd(0, -1, 0);
        total++;
        if (bif.mmio_addr !== 21'h00040 || bif.mmio_wr_data !== 32'h0000_00A5) begin
            bad++;
            $display("FAIL write_hold: addr=%h wd=%h, need 00040 000000a5", bif.mmio_addr, bif.mmio_wr_data);
        end
    endtask

    task automatic test_read;
        rd_val = 32'h1234_5678;
        set_read(24'h000060);
        do_cmd(0, -1, 0);
        do_cmd(1, -1, 0);
    endtask

    task automatic test_bad_opcode;
        cmd[0] = 8'hAA;
        do_cmd(0, -1, 0);
    endtask

    task automatic test_timeout;
        mon_q.delete();
        send_byte(8'h57);
        send_byte(8'h00);
        repeat (TO - 1) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL timeout_early: busy=%b after %0d idle cycles, need 1", busy, TO - 1);
        end
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || bif.rx_ready !== 1'b1) begin
            bad++;
            $display("FAIL timeout_expire: busy=%b rx_ready=%b, need 0 1", busy, bif.rx_ready);
        end
        total++;
        if (mon_q.size() != 0) begin
            bad++;
            $display("FAIL timeout_nobus: %0d cs cycles, need 0", mon_q.size());
        end
        rd_val = $urandom;
        set_read(24'h000020);
        do_cmd(0, -1, 0);
        // A byte arriving on the expiry edge is still accepted.
        rd_val = $urandom;
        set_read(24'h000040);
        do_cmd(0, 1, TO - 1);
    endtask

    task automatic test_addr_mask;
        rd_val = $urandom;
        set_read(24'hFFFFFF);
        do_cmd(0, -1, 0);
        total++;
        if (bif.mmio_addr !== 21'h1FFFFF) begin
            bad++;
            $display("FAIL addr_mask: addr=%h, need 1fffff", bif.mmio_addr);
        end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        int c = 0;
        rd_val = $urandom;
        set_read(24'h000104);
        for (int i = 0; i < 4; i++) send_byte(cmd[i]);
        bif.tx_ready = 1'b1;
        while (n < 2 && c < 50) begin
            @(negedge clk);
            if (bif.tx_valid && bif.tx_ready) n++;
            @(posedge clk);
            c++;
        end
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (n != 2 || bif.tx_valid !== 1'b0 || bif.mmio_cs !== 1'b0 || busy !== 1'b0 || bif.rx_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_resp: xfers=%0d tx_valid=%b cs=%b busy=%b rx_ready=%b, need 2 0 0 0 1",
                     n, bif.tx_valid, bif.mmio_cs, busy, bif.rx_ready);
        end
        bif.tx_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        set_write({$urandom} [23:0], $urandom);
        do_cmd(0, -1, 0);
        // Reset landing in the strobe cycle itself.
        set_read(24'h000008);
        for (int i = 0; i < 4; i++) send_byte(cmd[i]);
        total++;
        if (bif.mmio_cs !== 1'b1 || bif.mmio_rd !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_bus: cs=%b rd=%b, need 1 1", bif.mmio_cs, bif.mmio_rd);
        end
        reset = 1'b1;
        #1;
        total++;
        if (bif.mmio_cs !== 1'b0 || bif.mmio_rd !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_bus: cs=%b rd=%b busy=%b, need 0 0 0", bif.mmio_cs, bif.mmio_rd, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        rd_val = $urandom;
        do_cmd(0, -1, 0);
    endtask

    task automatic test_back_to_back;
        rd_val = 32'hCAFE_F00D;
        set_read(24'h000021);
        do_cmd(0, -1, 0);
        set_write(24'h0003FF, 32'h8765_4321);
        do_cmd(0, -1, 0);
        rd_val = 32'h0102_0304;
        set_read(24'h000022);
        do_cmd(0, -1, 0);
    endtask

    task automatic test_random;
        logic [23:0] a;
        int          k;
        for (int it = 0; it < 30; it++) begin
            a      = 24'($urandom);
            rd_val = $urandom;
            k      = $urandom_range(0, 2);
            if (k == 0) begin
                set_write(a, $urandom);
            end else if (k == 1) begin
                set_read(a);
            end else begin
                cmd[0] = 8'($urandom);
                if (cmd[0] == 8'h57 || cmd[0] == 8'h52) cmd[0] = 8'h00;
            end
            do_cmd(2, -1, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_opcode();
        test_timeout();
        test_addr_mask();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
